// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and sequencing controller for a 5-stage (F/D/E/M/W) pipeline.
//   - Combinational forwarding selects for the two E-stage ALU operands.
//   - Stall / flush controls for the F/D, D/E and E/M pipeline registers.
//     FLUSH_E drives the CLR of the D/E register.
//   - Multi-cycle data-memory sequencing: a req/ack wait state with a
//     timeout that parks the pipeline in HALT and raises a sticky MEM_ERR.
//
// Ports:
//   CLK, CLR                      clock (state on posedge), async active-high reset
//   RA1_D, RA2_D                  source registers of the instruction in D
//   RA1_E, RA2_E                  source registers of the instruction in E
//   WRITE_REG_E/M/W, REG_WRITE_E/M/W  destination register and write enable per stage
//   MEM_TO_REG_E                  instruction in E is a load
//   BRANCH_TAKEN_E                branch resolved taken in E
//   MEM_REQ_M, MEM_ACK            data-memory request in M / completion this cycle
//   FWD_A_E, FWD_B_E              operand select: 00 regfile, 01 W result, 10 M result
//   STALL_F/D/E/M                 hold the corresponding stage register
//   FLUSH_D, FLUSH_E              clear the F/D and D/E registers
//   BUBBLE_W                      M/W register captures a bubble
//   MEM_ERR                       sticky memory-timeout flag
//
// Optional feature macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters:
//   STALL_CNT (cycles with STALL_D), FLUSH_CNT (cycles with FLUSH_E),
//   WAIT_CNT (cycles spent in MEM_WAIT).
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,  // legal range 2..255
  parameter int CNT_W          = 8    // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [4:0] RA1_D,
  input  logic [4:0] RA2_D,
  input  logic [4:0] RA1_E,
  input  logic [4:0] RA2_E,
  input  logic [4:0] WRITE_REG_E,
  input  logic [4:0] WRITE_REG_M,
  input  logic [4:0] WRITE_REG_W,
  input  logic       REG_WRITE_E,
  input  logic       REG_WRITE_M,
  input  logic       REG_WRITE_W,
  input  logic       MEM_TO_REG_E,
  input  logic       BRANCH_TAKEN_E,
  input  logic       MEM_REQ_M,
  input  logic       MEM_ACK,
  output logic [1:0] FWD_A_E,
  output logic [1:0] FWD_B_E,
  output logic       STALL_F,
  output logic       STALL_D,
  output logic       STALL_E,
  output logic       STALL_M,
  output logic       FLUSH_D,
  output logic       FLUSH_E,
  output logic       BUBBLE_W,
  output logic       MEM_ERR
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT,
  output logic [31:0] WAIT_CNT
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  // Operand select for one E-stage source. r0 never forwards, and the M
  // stage holds the younger result so it wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] ra,
    input logic [4:0] wr_m,
    input logic       rw_m,
    input logic [4:0] wr_w,
    input logic       rw_w
  );
    if (rw_m && (wr_m != 5'd0) && (wr_m == ra))      return 2'b10;
    else if (rw_w && (wr_w != 5'd0) && (wr_w == ra)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign FWD_A_E = fwd_sel(RA1_E, WRITE_REG_M, REG_WRITE_M, WRITE_REG_W, REG_WRITE_W);
  assign FWD_B_E = fwd_sel(RA2_E, WRITE_REG_M, REG_WRITE_M, WRITE_REG_W, REG_WRITE_W);

  // Load in E whose destination is read by the instruction in D.
  logic w_load_use;
  assign w_load_use = MEM_TO_REG_E && REG_WRITE_E && (WRITE_REG_E != 5'd0) &&
                      ((WRITE_REG_E == RA1_D) || (WRITE_REG_E == RA2_D));

  logic w_mem_miss;
  assign w_mem_miss = MEM_REQ_M && !MEM_ACK;

  logic w_stall_fd;   // STALL_F and STALL_D
  logic w_stall_em;   // STALL_E and STALL_M, also BUBBLE_W
  logic w_flush_d;
  logic w_flush_e;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    w_stall_fd = 1'b0;
    w_stall_em = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;

    unique case (r_state)
      RUN, MEM_WAIT: begin
        // A pending memory access freezes the whole pipeline and masks branch
        // and load-use; an ack in MEM_WAIT drops the freeze in the same cycle
        // so the normal run rules take over immediately.
        if ((r_state == RUN) ? w_mem_miss : !MEM_ACK) begin
          w_stall_fd = 1'b1;
          w_stall_em = 1'b1;
        end else if (BRANCH_TAKEN_E) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_load_use) begin
          w_stall_fd = 1'b1;
          w_flush_e  = 1'b1;
        end
      end
      HALT: begin
        w_stall_fd = 1'b1;
        w_stall_em = 1'b1;
      end
      default: begin
        w_stall_fd = 1'b0;
      end
    endcase

    // Hold every control at its reset value while CLR is asserted.
    if (CLR) begin
      w_stall_fd = 1'b0;
      w_stall_em = 1'b0;
      w_flush_d  = 1'b0;
      w_flush_e  = 1'b0;
    end
  end

  assign STALL_F  = w_stall_fd;
  assign STALL_D  = w_stall_fd;
  assign STALL_E  = w_stall_em;
  assign STALL_M  = w_stall_em;
  assign BUBBLE_W = w_stall_em;
  assign FLUSH_D  = w_flush_d;
  assign FLUSH_E  = w_flush_e;
  assign MEM_ERR  = r_mem_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_miss) begin
            r_state <= MEM_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (MEM_ACK) begin
            r_state <= RUN;
          end else if (r_cnt == LAST_WAIT) begin
            r_state   <= HALT;
            r_mem_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HALT: begin
          r_state <= HALT;   // only CLR leaves HALT
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_wait_cnt;

  // Saturating event counters, sampled at the end of each cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_stall_fd && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_e  && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
      if ((r_state == MEM_WAIT) && (r_wait_cnt != '1)) r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;
  assign WAIT_CNT  = r_wait_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W).
- Generates forwarding selects for the E-stage ALU operands.
- Generates stall and flush controls for the F/D, D/E and E/M pipeline registers. FLUSH_E drives the CLR of the D/E register.
- Sequences multi-cycle data-memory accesses with a req/ack wait state and a timeout-to-halt.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in MEM_WAIT before entering HALT (legal range 2..255).
CNT_W, 8, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLK  in  1  clock; FSM state updates on posedge, so outputs settle before the pipeline registers capture on negedge.
CLR  in  1  reset, asynchronous, active-high.
RA1_D, RA2_D  in  5  source registers of the instruction in D.
RA1_E, RA2_E  in  5  source registers of the instruction in E.
WRITE_REG_E, WRITE_REG_M, WRITE_REG_W  in  5  destination registers per stage.
REG_WRITE_E, REG_WRITE_M, REG_WRITE_W  in  1  register-write enables per stage.
MEM_TO_REG_E  in  1  instruction in E is a load.
BRANCH_TAKEN_E  in  1  branch resolved taken in E.
MEM_REQ_M  in  1  instruction in M accesses data memory.
MEM_ACK  in  1  data memory completes the access this cycle.
FWD_A_E, FWD_B_E  out  2  operand select: 00 = register file, 01 = W result, 10 = M result.
STALL_F, STALL_D, STALL_E, STALL_M  out  1  hold the corresponding stage register.
FLUSH_D, FLUSH_E  out  1  clear the F/D and D/E registers (insert a bubble).
BUBBLE_W  out  1  M/W register captures a bubble (REG_WRITE = 0).
MEM_ERR  out  1  sticky: memory timeout occurred.

Behaviour:
- Register 0 is hardwired zero and is never a hazard source. Every match below requires WRITE_REG_x != 0.
- Forwarding (combinational, independent of FSM state):
  - FWD_A_E = 10 if REG_WRITE_M && WRITE_REG_M == RA1_E.
  - Otherwise 01 if REG_WRITE_W && WRITE_REG_W == RA1_E.
  - Otherwise 00.
  - M has priority over W. FWD_B_E is identical using RA2_E.
- Load-use hazard: LU = MEM_TO_REG_E && REG_WRITE_E && (WRITE_REG_E == RA1_D || WRITE_REG_E == RA2_D).
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN, counter = 0, MEM_ERR = 0.
- RUN:
  - If MEM_REQ_M && !MEM_ACK: STALL_F/D/E/M = 1 and BUBBLE_W = 1 this cycle. Next state MEM_WAIT, counter reset to 1.
  - Else if BRANCH_TAKEN_E: FLUSH_D = FLUSH_E = 1. No stalls.
  - Else if LU: STALL_F = STALL_D = 1, FLUSH_E = 1.
  - Else all controls 0.
  - A memory wait masks branch and LU; both are re-evaluated once the wait ends.
- MEM_WAIT:
  - STALL_F/D/E/M = 1 and BUBBLE_W = 1.
  - If MEM_ACK: all stalls and BUBBLE_W drop to 0 this cycle and the RUN rules above apply combinationally. Next state RUN.
  - Else if counter == TIMEOUT_CYCLES - 1: next state HALT and MEM_ERR is set.
  - Else the counter increments.
- HALT:
  - STALL_F/D/E/M = 1 and BUBBLE_W = 1 permanently. FLUSH_* = 0. MEM_ACK is ignored.
  - Only CLR exits HALT.
- Reset values of all outputs: stalls, flushes and BUBBLE_W = 0; MEM_ERR = 0. FWD_* follow their inputs and are 00 when all REG_WRITE_* = 0.
- CLR asserted mid-wait: state returns to RUN immediately (asynchronous), counter = 0, MEM_ERR = 0.
- MEM_ACK with no MEM_REQ_M outstanding is ignored.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three 32-bit outputs, each reset to 0 by CLR and saturating at all-ones:
  - STALL_CNT: cycles with STALL_D = 1.
  - FLUSH_CNT: cycles with FLUSH_E = 1.
  - WAIT_CNT: cycles spent in MEM_WAIT.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. WRITE_REG_M = 5, REG_WRITE_M = 1, WRITE_REG_W = 5, REG_WRITE_W = 1, RA1_E = 5 -> FWD_A_E = 10. With REG_WRITE_M = 0 -> FWD_A_E = 01. With RA1_E = 0 and both writers targeting r0 -> FWD_A_E = 00.
2. Load in E writing r3, RA2_D = 3 -> one cycle of STALL_F = STALL_D = FLUSH_E = 1; next cycle (load now in M) all deasserted.
3. BRANCH_TAKEN_E = 1 concurrent with LU = 1 -> FLUSH_D = FLUSH_E = 1, STALL_D = 0.
4. MEM_REQ_M = 1, MEM_ACK low for 3 cycles then high -> stalls high for 3 cycles; on the ack cycle stalls = 0; state returns to RUN.
5. TIMEOUT_CYCLES = 4, MEM_REQ_M held, MEM_ACK = 0 -> HALT entered after 4 stall cycles, MEM_ERR = 1 and stalls persist; a later MEM_ACK has no effect; CLR pulse -> MEM_ERR = 0, stalls = 0.
6. HAZARD_PERF_CNT_EN: scenario 4 followed by scenario 2 -> WAIT_CNT = 3, STALL_CNT = 4, FLUSH_CNT = 1.
